// File: rtl/cdm_msgld_rsp_model.sv
`default_nettype none
// ============================================================================
// Module      : cdm_msgld_rsp_model
// Description : Completer-side model of the CDM message-load path. Accepts
//               msgld descriptor requests into a small FIFO and returns each
//               one, strictly in order, as a multi-beat response packet after
//               a programmable number of idle cycles.
// Ports       : user_clk/user_reset      clock, async active-high reset
//               req_*                    request vld/rdy + {qid,tag,len}
//               cfg_lat                  idle cycles before first beat
//               rsp_*                    response beat stream vld/rdy
//               err_inj                  error-inject pulse
//               req_cnt/rsp_pkt_cnt      accepted requests / completed packets
// Options     : CDM_MSGLD_RSP_ERR_INJ_EN enables err_inj arming and rsp_err.
// Revision    : 1.0 - initial release
// ============================================================================
module cdm_msgld_rsp_model #(
    parameter int DATA_W     = 256,
    parameter int FIFO_DEPTH = 8,
    parameter int QID_W      = 12,
    parameter int LEN_W      = 16,
    parameter int TCQ        = 1
) (
    input  logic                          user_clk,
    input  logic                          user_reset,
    input  logic                          req_vld,
    output logic                          req_rdy,
    input  logic [QID_W-1:0]              req_qid,
    input  logic [7:0]                    req_tag,
    input  logic [LEN_W-1:0]              req_len,
    input  logic [7:0]                    cfg_lat,
    output logic                          rsp_vld,
    input  logic                          rsp_rdy,
    output logic [DATA_W-1:0]             rsp_dat,
    output logic [QID_W-1:0]              rsp_qid,
    output logic [7:0]                    rsp_tag,
    output logic                          rsp_sop,
    output logic                          rsp_eop,
    output logic [$clog2(DATA_W/8)-1:0]   rsp_mty,
    output logic                          rsp_err,
    input  logic                          err_inj,
    output logic [31:0]                   req_cnt,
    output logic [31:0]                   rsp_pkt_cnt
);

    localparam int c_BYTES = DATA_W / 8;
    localparam int c_BSH   = $clog2(c_BYTES);
    localparam int c_WORDS = DATA_W / 32;
    localparam int c_AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CW    = $clog2(FIFO_DEPTH + 1);
    localparam int c_EW    = QID_W + 8 + LEN_W;
    localparam logic [c_CW-1:0]  c_DEPTH    = c_CW'(FIFO_DEPTH);
    localparam logic [LEN_W:0]   c_BYTES_M1 = (LEN_W+1)'(c_BYTES - 1);
    localparam logic [LEN_W:0]   c_ONE      = (LEN_W+1)'(1);
    localparam int c_unused_tcq = TCQ;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t r_state, w_state_nxt;

    logic [c_EW-1:0]    r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]    r_wptr, r_rptr;
    logic [c_CW-1:0]    r_count, w_count_nxt;
    logic               r_req_rdy;
    logic               w_push, w_pop, w_empty;
    logic [c_EW-1:0]    w_head;
    logic [QID_W-1:0]   w_head_qid;
    logic [7:0]         w_head_tag;
    logic [LEN_W-1:0]   w_head_len;
    logic [LEN_W:0]     w_len_full, w_beats;
    logic [c_BSH-1:0]   w_head_mty;

    logic [QID_W-1:0]   r_qid;
    logic [7:0]         r_tag;
    logic [LEN_W:0]     r_beats, r_beat;
    logic [c_BSH-1:0]   r_mty;
    logic [7:0]         r_lat;
    logic [31:0]        r_req_cnt, r_pkt_cnt;
    logic               w_in_data, w_last, w_rsp_hs;
    logic [23:0]        w_base;
    logic [DATA_W-1:0]  w_dat;

    // ---------------- request FIFO ----------------
    assign w_push      = req_vld & r_req_rdy;
    assign w_empty     = (r_count == '0);
    assign w_count_nxt = r_count + c_CW'(w_push) - c_CW'(w_pop);
    assign w_head      = r_mem[r_rptr];
    assign w_head_qid  = w_head[c_EW-1 -: QID_W];
    assign w_head_tag  = w_head[LEN_W +: 8];
    assign w_head_len  = w_head[LEN_W-1:0];

    // Length 0 stands for 2^LEN_W bytes, hence the extra bit.
    assign w_len_full = (w_head_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, w_head_len};
    assign w_beats    = (w_len_full + c_BYTES_M1) >> c_BSH;
    // Empty bytes of the last beat = (-len) mod bytes-per-beat.
    assign w_head_mty = -w_head_len[c_BSH-1:0];

    always_ff @(posedge user_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {req_qid, req_tag, req_len};
        end
    end

    // ---------------- FSM ----------------
    assign w_in_data = (r_state == ST_DATA);
    assign w_last    = (r_beat == (r_beats - c_ONE));
    assign w_rsp_hs  = w_in_data & rsp_rdy;

    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = (cfg_lat == 8'd0) ? ST_DATA : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_lat == 8'd1) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (rsp_rdy && w_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            r_count   <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_req_rdy <= 1'b0;
            r_qid     <= '0;
            r_tag     <= '0;
            r_beats   <= '0;
            r_beat    <= '0;
            r_mty     <= '0;
            r_lat     <= '0;
            r_req_cnt <= '0;
            r_pkt_cnt <= '0;
        end else begin
            r_count   <= w_count_nxt;
            // Registered ready looks at post-edge occupancy, so a pop only
            // opens room from the following cycle onward.
            r_req_rdy <= (w_count_nxt < c_DEPTH);
            if (w_push) begin
                r_wptr    <= r_wptr + c_AW'(1);
                r_req_cnt <= r_req_cnt + 32'd1;
            end
            if (w_pop) begin
                r_rptr  <= r_rptr + c_AW'(1);
                r_qid   <= w_head_qid;
                r_tag   <= w_head_tag;
                r_beats <= w_beats;
                r_mty   <= w_head_mty;
                r_beat  <= '0;
                r_lat   <= cfg_lat;
            end else if (r_state == ST_WAIT) begin
                r_lat <= r_lat - 8'd1;
            end
            if (w_rsp_hs) begin
                r_beat <= r_beat + c_ONE;
                if (w_last) begin
                    r_pkt_cnt <= r_pkt_cnt + 32'd1;
                end
            end
        end
    end

    // Word w of beat b carries {tag, byte offset of that word}.
    assign w_base = 24'(r_beat) << c_BSH;

    for (genvar gi = 0; gi < c_WORDS; gi++) begin : g_word
        assign w_dat[gi*32 +: 32] = {r_tag, w_base + 24'(4 * gi)};
    end

    // Everything is forced to zero outside DATA so reset leaves all outputs 0.
    assign rsp_vld     = w_in_data;
    assign rsp_dat     = w_in_data ? w_dat : '0;
    assign rsp_qid     = w_in_data ? r_qid : '0;
    assign rsp_tag     = w_in_data ? r_tag : '0;
    assign rsp_sop     = w_in_data & (r_beat == '0);
    assign rsp_eop     = w_in_data & w_last;
    assign rsp_mty     = (w_in_data && w_last) ? r_mty : '0;
    assign req_rdy     = r_req_rdy;
    assign req_cnt     = r_req_cnt;
    assign rsp_pkt_cnt = r_pkt_cnt;

`ifdef CDM_MSGLD_RSP_ERR_INJ_EN
    logic r_arm, r_err;

    // A pulse coincident with a pop marks that popped packet directly.
    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            r_arm <= 1'b0;
            r_err <= 1'b0;
        end else if (w_pop) begin
            r_err <= r_arm | err_inj;
            r_arm <= 1'b0;
        end else if (err_inj) begin
            r_arm <= 1'b1;
        end
    end

    assign rsp_err = w_in_data & r_err;
`else
    logic w_unused_err_inj;
    assign w_unused_err_inj = err_inj;
    assign rsp_err          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cdm_msgld_rsp_model.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdm_msgld_rsp_model
// Description : Directed and randomised bench for cdm_msgld_rsp_model
//               (DATA_W=256, FIFO_DEPTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdm_msgld_rsp_model;

    localparam int DATA_W = 256;
    localparam int QID_W  = 12;
    localparam int LEN_W  = 16;
    localparam int BYTES  = 32;
    localparam int WORDS  = 8;

    logic               user_clk = 1'b0;
    logic               user_reset = 1'b1;
    logic               req_vld = 1'b0;
    logic               req_rdy;
    logic [QID_W-1:0]   req_qid = '0;
    logic [7:0]         req_tag = '0;
    logic [LEN_W-1:0]   req_len = '0;
    logic [7:0]         cfg_lat = '0;
    logic               rsp_vld;
    logic               rsp_rdy = 1'b1;
    logic [DATA_W-1:0]  rsp_dat;
    logic [QID_W-1:0]   rsp_qid;
    logic [7:0]         rsp_tag;
    logic               rsp_sop;
    logic               rsp_eop;
    logic [4:0]         rsp_mty;
    logic               rsp_err;
    logic               err_inj = 1'b0;
    logic [31:0]        req_cnt;
    logic [31:0]        rsp_pkt_cnt;

    int checks = 0;
    int errors = 0;
    int exp_tag_q[$];
    int exp_qid_q[$];
    int exp_len_q[$];

    cdm_msgld_rsp_model #(
        .DATA_W(DATA_W), .FIFO_DEPTH(8), .QID_W(QID_W), .LEN_W(LEN_W), .TCQ(1)
    ) dut (
        .user_clk(user_clk), .user_reset(user_reset),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_qid(req_qid),
        .req_tag(req_tag), .req_len(req_len), .cfg_lat(cfg_lat),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_dat(rsp_dat),
        .rsp_qid(rsp_qid), .rsp_tag(rsp_tag), .rsp_sop(rsp_sop),
        .rsp_eop(rsp_eop), .rsp_mty(rsp_mty), .rsp_err(rsp_err),
        .err_inj(err_inj), .req_cnt(req_cnt), .rsp_pkt_cnt(rsp_pkt_cnt)
    );

    always #5 user_clk = ~user_clk;

    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    task automatic do_reset();
        user_reset = 1'b1;
        tick();
        user_reset = 1'b0;
        tick();
    endtask

    // Presents one request and returns one ns after its handshake edge.
    task automatic send_req(input int qid, input int tag, input int len);
        int w;
        w = 0;
        req_vld = 1'b1;
        req_qid = QID_W'(qid);
        req_tag = 8'(tag);
        req_len = LEN_W'(len);
        while (!req_rdy && w < 300) begin
            tick();
            w++;
        end
        checks++;
        if (!req_rdy) begin
            errors++;
            $display("FAIL req_accept_timeout: req_rdy=%0b required 1", req_rdy);
        end else begin
            exp_qid_q.push_back(qid);
            exp_tag_q.push_back(tag);
            exp_len_q.push_back(len);
        end
        tick();
        req_vld = 1'b0;
    endtask

    task automatic wait_vld(output int waited);
        waited = 0;
        while (!rsp_vld && waited < 500) begin
            tick();
            waited++;
        end
    endtask

    // Receives one packet; returns beat count, count of bad beats/stall
    // violations, mty seen on eop (-1 if none) and beats flagged rsp_err.
    task automatic rx_pkt(input int etag, input int eqid, input int elen, input bit rnd,
                          output int nbeats, output int nbad, output int last_mty, output int nerr);
        int lenb, ebeats, emty, b, guard;
        bit done, stalled, bad;
        logic [DATA_W-1:0] s_dat;
        logic [QID_W-1:0]  s_qid;
        logic [7:0]        s_tag;
        logic [4:0]        s_mty;
        logic              s_sop, s_eop, s_err;
        logic [31:0]       ew;
        lenb   = (elen == 0) ? (1 << LEN_W) : elen;
        ebeats = (lenb + BYTES - 1) / BYTES;
        emty   = ebeats * BYTES - lenb;
        b = 0; guard = 0; done = 0; stalled = 0;
        nbad = 0; nerr = 0; last_mty = -1;
        s_dat = '0; s_qid = '0; s_tag = '0; s_mty = '0; s_sop = 0; s_eop = 0; s_err = 0;
        while (!done && guard < 10000) begin
            rsp_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled) begin
                if (!rsp_vld || rsp_dat !== s_dat || rsp_qid !== s_qid || rsp_tag !== s_tag ||
                    rsp_mty !== s_mty || rsp_sop !== s_sop || rsp_eop !== s_eop || rsp_err !== s_err)
                    nbad++;
                stalled = 0;
            end
            if (rsp_vld) begin
                if (rsp_rdy) begin
                    bad = 0;
                    if (rsp_sop !== (b == 0)) bad = 1;
                    if (rsp_eop !== (b == ebeats - 1)) bad = 1;
                    if (rsp_qid !== QID_W'(eqid) || rsp_tag !== 8'(etag)) bad = 1;
                    if (rsp_mty !== ((b == ebeats - 1) ? 5'(emty) : 5'd0)) bad = 1;
                    for (int w = 0; w < WORDS; w++) begin
                        ew = {8'(etag), 24'(b * BYTES + 4 * w)};
                        if (rsp_dat[w*32 +: 32] !== ew) bad = 1;
                    end
                    if (bad) nbad++;
                    if (rsp_err) nerr++;
                    if (rsp_eop) last_mty = int'(rsp_mty);
                    b++;
                    if (rsp_eop || b >= ebeats) done = 1;
                end else begin
                    s_dat = rsp_dat; s_qid = rsp_qid; s_tag = rsp_tag; s_mty = rsp_mty;
                    s_sop = rsp_sop; s_eop = rsp_eop; s_err = rsp_err;
                    stalled = 1;
                end
            end
            tick();
            guard++;
        end
        nbeats = b;
    endtask

    task automatic test_reset();
        user_reset = 1'b1;
        tick();
        tick();
        checks++;
        if (req_rdy !== 1'b0 || rsp_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: req_rdy=%0b rsp_vld=%0b required 0 0", req_rdy, rsp_vld);
        end
        checks++;
        if (req_cnt !== 32'd0 || rsp_pkt_cnt !== 32'd0 || rsp_err !== 1'b0 || rsp_dat !== '0) begin
            errors++;
            $display("FAIL reset_out: req_cnt=%0d pkt=%0d err=%0b dat=%h required zeros",
                     req_cnt, rsp_pkt_cnt, rsp_err, rsp_dat);
        end
        user_reset = 1'b0;
        tick();
        checks++;
        if (req_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_rdy: req_rdy=%0b required 1", req_rdy);
        end
    endtask

    task automatic test_basic();
        int w;
        cfg_lat = 8'd0;
        rsp_rdy = 1'b1;
        send_req(12'h123, 8'h5A, 64);
        wait_vld(w);
        checks++;
        if (1 + w != 2) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles required 2", 1 + w);
        end
        checks++;
        if (rsp_sop !== 1'b1 || rsp_eop !== 1'b0 || rsp_mty !== 5'd0 ||
            rsp_dat[31:0] !== 32'h5A000000 || rsp_qid !== 12'h123) begin
            errors++;
            $display("FAIL basic_beat0: sop=%0b eop=%0b mty=%0d w0=%h qid=%h required 1 0 0 5a000000 123",
                     rsp_sop, rsp_eop, rsp_mty, rsp_dat[31:0], rsp_qid);
        end
        tick();
        checks++;
        if (rsp_vld !== 1'b1 || rsp_sop !== 1'b0 || rsp_eop !== 1'b1 || rsp_mty !== 5'd0 ||
            rsp_dat[31:0] !== 32'h5A000020 || rsp_dat[63:32] !== 32'h5A000024) begin
            errors++;
            $display("FAIL basic_beat1: vld=%0b sop=%0b eop=%0b mty=%0d w0=%h w1=%h required 1 0 1 0 5a000020 5a000024",
                     rsp_vld, rsp_sop, rsp_eop, rsp_mty, rsp_dat[31:0], rsp_dat[63:32]);
        end
        tick();
        checks++;
        if (rsp_vld !== 1'b0 || req_cnt !== 32'd1 || rsp_pkt_cnt !== 32'd1) begin
            errors++;
            $display("FAIL basic_done: vld=%0b req_cnt=%0d pkt=%0d required 0 1 1",
                     rsp_vld, req_cnt, rsp_pkt_cnt);
        end
    endtask

    task automatic test_len(input int len, input int exp_beats, input int exp_mty);
        int nb, nbad, mty, nerr;
        send_req(12'h0F0, 8'hC3, len);
        rx_pkt(8'hC3, 12'h0F0, len, 1'b0, nb, nbad, mty, nerr);
        checks++;
        if (nb != exp_beats || nbad != 0) begin
            errors++;
            $display("FAIL len%0d_beats: beats=%0d bad=%0d required %0d 0", len, nb, nbad, exp_beats);
        end
        checks++;
        if (mty != exp_mty) begin
            errors++;
            $display("FAIL len%0d_mty: mty=%0d required %0d", len, mty, exp_mty);
        end
    endtask

    task automatic test_latency();
        int w, nb, nbad, mty, nerr;
        cfg_lat = 8'd5;
        send_req(12'h005, 8'h11, 32);
        wait_vld(w);
        checks++;
        if (1 + w != 7) begin
            errors++;
            $display("FAIL lat5_latency: got %0d cycles required 7", 1 + w);
        end
        rx_pkt(8'h11, 12'h005, 32, 1'b0, nb, nbad, mty, nerr);
        checks++;
        if (nb != 1 || nbad != 0) begin
            errors++;
            $display("FAIL lat5_pkt: beats=%0d bad=%0d required 1 0", nb, nbad);
        end
        cfg_lat = 8'd0;
    endtask

    task automatic test_back_to_back();
        int acc, good, nb, nbad, mty, nerr;
        do_reset();
        cfg_lat = 8'd0;
        rsp_rdy = 1'b0;
        acc = 0;
        req_vld = 1'b1;
        req_len = LEN_W'(32);
        req_qid = 12'h0AB;
        for (int c = 0; c < 30 && acc < 10; c++) begin
            req_tag = 8'(acc);
            if (req_rdy) acc++;
            tick();
        end
        req_vld = 1'b0;
        checks++;
        if (acc != 9) begin
            errors++;
            $display("FAIL b2b_accepted: accepted=%0d required 9", acc);
        end
        checks++;
        if (req_rdy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_rdy_low: req_rdy=%0b required 0", req_rdy);
        end
        good = 0;
        for (int i = 0; i < 9; i++) begin
            rx_pkt(i, 12'h0AB, 32, 1'b0, nb, nbad, mty, nerr);
            if (nb == 1 && nbad == 0) good++;
        end
        checks++;
        if (good != 9) begin
            errors++;
            $display("FAIL b2b_order: good packets=%0d required 9", good);
        end
        tick();
        checks++;
        if (req_cnt !== 32'd9 || rsp_pkt_cnt !== 32'd9) begin
            errors++;
            $display("FAIL b2b_counts: req_cnt=%0d pkt=%0d required 9 9", req_cnt, rsp_pkt_cnt);
        end
    endtask

    task automatic test_random();
        int r0, p0;
        exp_tag_q.delete();
        exp_qid_q.delete();
        exp_len_q.delete();
        r0 = int'(req_cnt);
        p0 = int'(rsp_pkt_cnt);
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    cfg_lat = 8'($urandom_range(0, 3));
                    send_req(int'($urandom_range(0, 4095)), i, int'($urandom_range(1, 200)));
                    repeat ($urandom_range(0, 2)) tick();
                end
            end
            begin
                int w, nb, nbad, mty, nerr, et, eq, el, lb, eb;
                for (int i = 0; i < 100; i++) begin
                    wait_vld(w);
                    checks++;
                    if (!rsp_vld || exp_tag_q.size() == 0) begin
                        errors++;
                        $display("FAIL rnd_timeout: pkt %0d vld=%0b queued=%0d required 1 >0",
                                 i, rsp_vld, exp_tag_q.size());
                        break;
                    end
                    et = exp_tag_q.pop_front();
                    eq = exp_qid_q.pop_front();
                    el = exp_len_q.pop_front();
                    lb = el;
                    eb = (lb + BYTES - 1) / BYTES;
                    rx_pkt(et, eq, el, 1'b1, nb, nbad, mty, nerr);
                    checks++;
                    if (nb != eb || nbad != 0 || mty != eb * BYTES - lb) begin
                        errors++;
                        $display("FAIL rnd_pkt: pkt %0d beats=%0d bad=%0d mty=%0d required %0d 0 %0d",
                                 i, nb, nbad, mty, eb, eb * BYTES - lb);
                    end
                end
            end
        join
        rsp_rdy = 1'b1;
        cfg_lat = 8'd0;
        tick();
        checks++;
        if (int'(req_cnt) - r0 != 100 || int'(rsp_pkt_cnt) - p0 != 100) begin
            errors++;
            $display("FAIL rnd_counts: req delta=%0d pkt delta=%0d required 100 100",
                     int'(req_cnt) - r0, int'(rsp_pkt_cnt) - p0);
        end
    endtask

    task automatic test_err_inj();
        int nb0, nbad0, m0, e0, nb1, nbad1, m1, e1, exp_e0;
`ifdef CDM_MSGLD_RSP_ERR_INJ_EN
        exp_e0 = 2;
`else
        exp_e0 = 0;
`endif
        cfg_lat = 8'd0;
        rsp_rdy = 1'b1;
        err_inj = 1'b1;
        tick();
        err_inj = 1'b0;
        send_req(12'h001, 8'hE0, 64);
        send_req(12'h002, 8'hE1, 64);
        rx_pkt(8'hE0, 12'h001, 64, 1'b0, nb0, nbad0, m0, e0);
        rx_pkt(8'hE1, 12'h002, 64, 1'b0, nb1, nbad1, m1, e1);
        checks++;
        if (e0 != exp_e0 || nb0 != 2 || nbad0 != 0) begin
            errors++;
            $display("FAIL err_first: err beats=%0d beats=%0d bad=%0d required %0d 2 0", e0, nb0, nbad0, exp_e0);
        end
        checks++;
        if (e1 != 0 || nb1 != 2 || nbad1 != 0) begin
            errors++;
            $display("FAIL err_second: err beats=%0d beats=%0d bad=%0d required 0 2 0", e1, nb1, nbad1);
        end
    endtask

    task automatic test_reset_mid();
        int w, vcount;
        do_reset();
        cfg_lat = 8'd0;
        rsp_rdy = 1'b1;
        send_req(12'h007, 8'h33, 128);
        wait_vld(w);
        tick();
        checks++;
        if (rsp_vld !== 1'b1 || rsp_sop !== 1'b0 || rsp_dat[31:0] !== 32'h33000020) begin
            errors++;
            $display("FAIL rstmid_beat1: vld=%0b sop=%0b w0=%h required 1 0 33000020", rsp_vld, rsp_sop, rsp_dat[31:0]);
        end
        user_reset = 1'b1;
        #1;
        checks++;
        if (rsp_vld !== 1'b0 || req_rdy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: vld=%0b req_rdy=%0b required 0 0", rsp_vld, req_rdy);
        end
        checks++;
        if (req_cnt !== 32'd0 || rsp_pkt_cnt !== 32'd0) begin
            errors++;
            $display("FAIL rstmid_counts: req_cnt=%0d pkt=%0d required 0 0", req_cnt, rsp_pkt_cnt);
        end
        tick();
        tick();
        user_reset = 1'b0;
        vcount = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (rsp_vld) vcount++;
        end
        checks++;
        if (vcount != 0 || req_rdy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_residual: vld cycles=%0d req_rdy=%0b required 0 1", vcount, req_rdy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len(40, 2, 24);
        test_len(0, 2048, 0);
        test_len(33, 2, 31);
        test_latency();
        test_back_to_back();
        test_random();
        test_err_inj();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
